// File: rtl/timer_pkg.sv
// Shared types, BCD limits and helpers for the time-of-day / chime / alarm block.
package timer_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_MIN  = 2'd1,
        SET_HOUR = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        BEE_OFF   = 2'b00,
        BEE_PRE   = 2'b01,
        BEE_HOUR  = 2'b10,
        BEE_ALARM = 2'b11
    } bee_e;

    localparam logic [7:0] BCD_ZERO = 8'h00;
    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] H24_MAX  = 8'h23;
    localparam logic [7:0] H12_MAX  = 8'h12;
    localparam logic [7:0] H12_MIN  = 8'h01;
    localparam logic [7:0] PRE_LAST = 8'h58;

    function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v >= lo) && (v <= hi);
    endfunction

    function automatic logic [7:0] to_bcd8(input int n);
        logic [7:0] r;
        r[7:4] = 4'((n / 32'sd10) % 32'sd10);
        r[3:0] = 4'(n % 32'sd10);
        return r;
    endfunction

endpackage

// File: rtl/timer_bcd_cnt.sv
// Two-digit BCD counter wrapping MAX -> MIN; carry flags an increment at MAX.
module timer_bcd_cnt #(
    parameter logic [7:0] MAX     = 8'h59,
    parameter logic [7:0] MIN     = 8'h00,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    output logic [7:0] value,
    output logic       carry
);

    logic [7:0] value_r;
    logic [7:0] next_s;

    // BCD successor with wrap
    always_comb begin
        next_s = value_r;
        if (value_r == MAX) begin
            next_s = MIN;
        end else if (value_r[3:0] == 4'd9) begin
            next_s = {value_r[7:4] + 4'd1, 4'd0};
        end else begin
            next_s = {value_r[7:4], value_r[3:0] + 4'd1};
        end
    end

    // counter register; clear beats increment
    always_ff @(posedge clk) begin
        if (rst) begin
            value_r <= RST_VAL;
        end else if (clr) begin
            value_r <= MIN;
        end else if (inc) begin
            value_r <= next_s;
        end
    end

    assign value = value_r;
    assign carry = inc & (value_r == MAX);

endmodule

// File: rtl/timer_chime_alarm.sv
// HH:MM:SS BCD timekeeping with fast-set modes, hourly chime and N alarm slots,
// all driven by tick-enable pulses in one clock domain.
module timer_chime_alarm
    import timer_pkg::*;
#(
    parameter int N_ALARM     = 2,
    parameter int H24         = 1,
    parameter int CHIME_START = 50,
    parameter int ALARM_SECS  = 30,
    localparam int IDX_W      = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_1hz,
    input  logic               tick_fast,
    input  logic               set_min,
    input  logic               set_hour,
    input  logic [N_ALARM-1:0] alarm_en,
    input  logic               alarm_wr,
    input  logic [IDX_W-1:0]   alarm_idx,
    input  logic [7:0]         alarm_hh,
    input  logic [7:0]         alarm_mm,
    input  logic               alarm_ack,
    output logic [3:0]         h1,
    output logic [3:0]         h2,
    output logic [3:0]         m1,
    output logic [3:0]         m2,
    output logic [3:0]         s1,
    output logic [3:0]         s2,
    output logic [1:0]         bee_out,
    output logic [N_ALARM-1:0] alarm_hit
);

    localparam logic [7:0] HOUR_MIN  = (H24 != 0) ? BCD_ZERO : H12_MIN;
    localparam logic [7:0] HOUR_MAX  = (H24 != 0) ? H24_MAX  : H12_MAX;
    localparam logic [7:0] HOUR_RST  = (H24 != 0) ? BCD_ZERO : H12_MAX;
    localparam logic [7:0] CHIME_BCD = to_bcd8(CHIME_START);
    localparam logic [5:0] RING_LOAD = 6'(ALARM_SECS);

    mode_e mode_r;
    mode_e mode_nxt_s;
    bee_e  bee_r;
    bee_e  bee_nxt_s;

    logic [7:0] sec_s, min_s, hour_s;
    logic       sec_carry_s, min_carry_s, hour_carry_unused_s;
    logic       run_s, sec_inc_s, sec_clr_s, min_inc_s, hour_inc_s;
    logic       sec_wrap_r;
    logic       wr_ok_s, pre_s;

    logic [7:0]         slot_hh_r [N_ALARM];
    logic [7:0]         slot_mm_r [N_ALARM];
    logic [5:0]         cnt_r     [N_ALARM];
    logic [5:0]         cnt_n_s   [N_ALARM];
    logic [N_ALARM-1:0] hit_r, hit_n_s, trig_s, wr_sel_s;

    // requested mode from the set levels; minute set dominates
    always_comb begin
        if (set_min) begin
            mode_nxt_s = SET_MIN;
        end else if (set_hour) begin
            mode_nxt_s = SET_HOUR;
        end else begin
            mode_nxt_s = RUN;
        end
    end

    assign run_s      = (mode_r == RUN);
    assign sec_inc_s  = run_s & tick_1hz;
    assign sec_clr_s  = (mode_r == SET_MIN);
    // in SET_MIN the minute wrap must not reach the hours, hence the run_s gate
    assign min_inc_s  = (run_s & sec_carry_s) | ((mode_r == SET_MIN) & tick_fast);
    assign hour_inc_s = (run_s & min_carry_s) | ((mode_r == SET_HOUR) & tick_fast);

    timer_bcd_cnt #(.MAX(SEC_MAX), .MIN(BCD_ZERO), .RST_VAL(BCD_ZERO)) u_sec (
        .clk(clk), .rst(rst), .inc(sec_inc_s), .clr(sec_clr_s), .value(sec_s), .carry(sec_carry_s)
    );
    timer_bcd_cnt #(.MAX(MIN_MAX), .MIN(BCD_ZERO), .RST_VAL(BCD_ZERO)) u_min (
        .clk(clk), .rst(rst), .inc(min_inc_s), .clr(1'b0), .value(min_s), .carry(min_carry_s)
    );
    timer_bcd_cnt #(.MAX(HOUR_MAX), .MIN(HOUR_MIN), .RST_VAL(HOUR_RST)) u_hour (
        .clk(clk), .rst(rst), .inc(hour_inc_s), .clr(1'b0), .value(hour_s), .carry(hour_carry_unused_s)
    );

    // mode register and "just entered SS=00" strobe for alarm matching
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r     <= RUN;
            sec_wrap_r <= 1'b0;
        end else begin
            mode_r     <= mode_nxt_s;
            sec_wrap_r <= sec_carry_s;
        end
    end

    assign wr_ok_s = bcd_valid(alarm_hh, HOUR_MIN, HOUR_MAX) && bcd_valid(alarm_mm, BCD_ZERO, MIN_MAX);
    assign pre_s   = (min_s == MIN_MAX) && !sec_s[0] && (sec_s >= CHIME_BCD) && (sec_s <= PRE_LAST);

    // per-slot write select and trigger match
    always_comb begin
        for (int k = 0; k < N_ALARM; k++) begin
            wr_sel_s[k] = alarm_wr && (alarm_idx == IDX_W'(k));
            trig_s[k]   = alarm_en[k] && run_s && sec_wrap_r &&
                          (hour_s == slot_hh_r[k]) && (min_s == slot_mm_r[k]);
        end
    end

    // ring state: silencing sources outrank a trigger in the same cycle
    always_comb begin
        for (int k = 0; k < N_ALARM; k++) begin
            hit_n_s[k] = hit_r[k];
            cnt_n_s[k] = cnt_r[k];
            if (alarm_ack || !alarm_en[k] || wr_sel_s[k] || (mode_nxt_s != RUN)) begin
                hit_n_s[k] = 1'b0;
                cnt_n_s[k] = 6'd0;
            end else if (trig_s[k]) begin
                hit_n_s[k] = 1'b1;
                cnt_n_s[k] = RING_LOAD;
            end else if (hit_r[k] && sec_inc_s) begin
                if (cnt_r[k] <= 6'd1) begin
                    hit_n_s[k] = 1'b0;
                    cnt_n_s[k] = 6'd0;
                end else begin
                    cnt_n_s[k] = cnt_r[k] - 6'd1;
                end
            end else begin
                hit_n_s[k] = hit_r[k];
            end
        end
    end

    // buzzer code; uses next ring state so silencing shows in the same cycle as alarm_hit
    always_comb begin
        if (|hit_n_s) begin
            bee_nxt_s = BEE_ALARM;
        end else if ((mode_r != RUN) || (mode_nxt_s != RUN)) begin
            bee_nxt_s = BEE_OFF;
        end else if ((min_s == BCD_ZERO) && (sec_s == BCD_ZERO)) begin
            bee_nxt_s = BEE_HOUR;
        end else if (pre_s) begin
            bee_nxt_s = BEE_PRE;
        end else begin
            bee_nxt_s = BEE_OFF;
        end
    end

    // alarm slots, ring flags, ring counters and buzzer register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_ALARM; k++) begin
                slot_hh_r[k] <= HOUR_RST;
                slot_mm_r[k] <= BCD_ZERO;
                cnt_r[k]     <= 6'd0;
            end
            hit_r <= {N_ALARM{1'b0}};
            bee_r <= BEE_OFF;
        end else begin
            for (int k = 0; k < N_ALARM; k++) begin
                if (wr_sel_s[k] && wr_ok_s) begin
                    slot_hh_r[k] <= alarm_hh;
                    slot_mm_r[k] <= alarm_mm;
                end
                cnt_r[k] <= cnt_n_s[k];
            end
            hit_r <= hit_n_s;
            bee_r <= bee_nxt_s;
        end
    end

    assign h1        = hour_s[7:4];
    assign h2        = hour_s[3:0];
    assign m1        = min_s[7:4];
    assign m2        = min_s[3:0];
    assign s1        = sec_s[7:4];
    assign s2        = sec_s[3:0];
    assign bee_out   = bee_r;
    assign alarm_hit = hit_r;

endmodule
